// File: rtl/multicycle_control_fsm_if.sv
// Control/datapath bundle for the multicycle MIPS control FSM.
// The master side is the FSM; the slave side is the datapath/IR/memory.
interface multicycle_control_fsm_if #(
    parameter int ALUOPW = 4
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              zero;
    logic              ihit;
    logic              dhit;
    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic              irWEN;
    logic              pcWEN;
    logic              regWEN;
    logic [1:0]        pcSrc;
    logic [1:0]        aluSrc;
    logic [1:0]        regDst;
    logic [1:0]        memToReg;
    logic [1:0]        extSel;
    logic [ALUOPW-1:0] aluOp;
    logic [2:0]        state;
    logic              retire;
    logic              halt;
    logic              illegal;
    logic              memTimeout;

    modport master (
        input  opcode, funct, zero, ihit, dhit,
        output iREN, dREN, dWEN, irWEN, pcWEN, regWEN, pcSrc, aluSrc, regDst,
               memToReg, extSel, aluOp, state, retire, halt, illegal, memTimeout
    );

    modport slave (
        output opcode, funct, zero, ihit, dhit,
        input  iREN, dREN, dWEN, irWEN, pcWEN, regWEN, pcSrc, aluSrc, regDst,
               memToReg, extSel, aluOp, state, retire, halt, illegal, memTimeout
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, waits on
// memory handshakes, and latches sticky halt/illegal/timeout flags.
module multicycle_control_fsm #(
    parameter int WAIT_MAX   = 16,
    parameter int TIMEOUT_EN = 1,
    parameter int ALUOPW     = 4
) (
    input logic                     CLK,
    input logic                     nRST,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    localparam int              CW       = $clog2(WAIT_MAX);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW    = 6'h2b,
                           OP_HALT  = 6'h3f;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_JR  = 6'h08,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                           F_SUBU = 6'h23, F_AND = 6'h24, F_OR  = 6'h25,
                           F_XOR = 6'h26, F_NOR  = 6'h27, F_SLT = 6'h2a,
                           F_SLTU = 6'h2b;

    localparam logic [ALUOPW-1:0] ALU_SLL = ALUOPW'(0),  ALU_SRL = ALUOPW'(1),
                                  ALU_ADD = ALUOPW'(2),  ALU_SUB = ALUOPW'(3),
                                  ALU_AND = ALUOPW'(4),  ALU_OR  = ALUOPW'(5),
                                  ALU_XOR = ALUOPW'(6),  ALU_NOR = ALUOPW'(7),
                                  ALU_SLT = ALUOPW'(10), ALU_SLTU = ALUOPW'(11);

    state_t            state, next;
    logic [CW-1:0]     cnt, cnt_d;
    logic              halt_q, illegal_q, timeout_q;
    logic              set_ill, set_to, wait_last;

    logic              op_ok, funct_ok, bad_instr;
    logic [ALUOPW-1:0] exec_op;
    logic [1:0]        exec_src, exec_ext;

    // Instruction decode; the IR holds opcode/funct stable after FETCH.
    always_comb begin
        exec_op  = ALU_ADD;
        exec_src = 2'b01;
        exec_ext = 2'b00;
        op_ok    = 1'b1;
        funct_ok = 1'b1;
        case (bus.opcode)
            OP_RTYPE: begin
                exec_src = 2'b00;
                case (bus.funct)
                    F_SLL:         begin exec_op = ALU_SLL; exec_src = 2'b10; end
                    F_SRL:         begin exec_op = ALU_SRL; exec_src = 2'b10; end
                    F_ADD, F_ADDU: exec_op = ALU_ADD;
                    F_SUB, F_SUBU: exec_op = ALU_SUB;
                    F_AND:         exec_op = ALU_AND;
                    F_OR:          exec_op = ALU_OR;
                    F_XOR:         exec_op = ALU_XOR;
                    F_NOR:         exec_op = ALU_NOR;
                    F_SLT:         exec_op = ALU_SLT;
                    F_SLTU:        exec_op = ALU_SLTU;
                    F_JR:          exec_op = ALU_ADD;
                    default:       funct_ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_HALT: exec_op = ALU_ADD;
            OP_BEQ, OP_BNE: begin
                exec_op  = ALU_SUB;
                exec_src = 2'b00;
                exec_ext = 2'b01;
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: exec_ext = 2'b01;
            OP_SLTI:  begin exec_op = ALU_SLT;  exec_ext = 2'b01; end
            OP_SLTIU: begin exec_op = ALU_SLTU; exec_ext = 2'b01; end
            OP_ANDI:  exec_op = ALU_AND;
            OP_ORI:   exec_op = ALU_OR;
            OP_XORI:  exec_op = ALU_XOR;
            OP_LUI:   exec_ext = 2'b10;
            default:  op_ok = 1'b0;
        endcase
        bad_instr = !op_ok || !funct_ok;
    end

    assign wait_last = (TIMEOUT_EN != 0) && (cnt == CNT_LAST);

    always_comb begin
        next         = state;
        set_ill      = 1'b0;
        set_to       = 1'b0;
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.irWEN    = 1'b0;
        bus.pcWEN    = 1'b0;
        bus.regWEN   = 1'b0;
        bus.retire   = 1'b0;
        bus.pcSrc    = 2'b00;
        bus.aluSrc   = 2'b00;
        bus.regDst   = 2'b00;
        bus.memToReg = 2'b00;
        bus.extSel   = 2'b00;
        bus.aluOp    = '0;
        case (state)
            FETCH: begin
                bus.iREN = 1'b1;
                if (bus.ihit) begin
                    bus.irWEN = 1'b1;
                    bus.pcWEN = 1'b1;
                    next      = DECODE;
                end else if (wait_last) begin
                    set_to = 1'b1;
                    next   = HALTED;
                end
            end
            DECODE: begin
                if (bad_instr) begin
                    set_ill = 1'b1;
                    next    = HALTED;
                end else begin
                    case (bus.opcode)
                        OP_J: begin
                            bus.pcWEN  = 1'b1;
                            bus.pcSrc  = 2'b10;
                            bus.retire = 1'b1;
                            next       = FETCH;
                        end
                        OP_JAL: begin
                            bus.pcWEN    = 1'b1;
                            bus.pcSrc    = 2'b10;
                            bus.regWEN   = 1'b1;
                            bus.regDst   = 2'b10;
                            bus.memToReg = 2'b10;
                            bus.retire   = 1'b1;
                            next         = FETCH;
                        end
                        OP_HALT: next = HALTED;
                        OP_RTYPE: begin
                            if (bus.funct == F_JR) begin
                                bus.pcWEN  = 1'b1;
                                bus.pcSrc  = 2'b11;
                                bus.retire = 1'b1;
                                next       = FETCH;
                            end else begin
                                next = EXEC;
                            end
                        end
                        default: next = EXEC;
                    endcase
                end
            end
            EXEC: begin
                bus.aluOp  = exec_op;
                bus.aluSrc = exec_src;
                bus.extSel = exec_ext;
                if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) begin
                    bus.pcWEN  = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
                    bus.pcSrc  = 2'b01;
                    bus.retire = 1'b1;
                    next       = FETCH;
                end else if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    next = MEM;
                end else begin
                    next = WB;
                end
            end
            MEM: begin
                // Address stays on the ALU output for the whole access.
                bus.aluOp  = ALU_ADD;
                bus.aluSrc = 2'b01;
                bus.extSel = 2'b01;
                bus.dREN   = (bus.opcode == OP_LW);
                bus.dWEN   = (bus.opcode == OP_SW);
                if (bus.dhit) begin
                    bus.retire = (bus.opcode == OP_SW);
                    next       = (bus.opcode == OP_LW) ? WB : FETCH;
                end else if (wait_last) begin
                    set_to = 1'b1;
                    next   = HALTED;
                end
            end
            WB: begin
                bus.aluOp    = exec_op;
                bus.aluSrc   = exec_src;
                bus.extSel   = exec_ext;
                bus.regWEN   = 1'b1;
                bus.retire   = 1'b1;
                bus.regDst   = (bus.opcode == OP_RTYPE) ? 2'b00 : 2'b01;
                bus.memToReg = (bus.opcode == OP_LW)  ? 2'b01 :
                               (bus.opcode == OP_LUI) ? 2'b11 : 2'b00;
                next         = FETCH;
            end
            HALTED:  next = HALTED;
            default: next = FETCH;
        endcase
    end

    // Counts unacknowledged request cycles; any hit or state change clears it.
    always_comb begin
        cnt_d = '0;
        if (next == state &&
            ((state == FETCH && !bus.ihit) || (state == MEM && !bus.dhit)))
            cnt_d = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            cnt       <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= next;
            cnt   <= cnt_d;
            if (next == HALTED) halt_q    <= 1'b1;
            if (set_ill)        illegal_q <= 1'b1;
            if (set_to)         timeout_q <= 1'b1;
        end
    end

    assign bus.state      = state;
    assign bus.halt       = halt_q;
    assign bus.illegal    = illegal_q;
    assign bus.memTimeout = timeout_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against a per-instruction
// expected-trace model built from instruction class and handshake latencies.
module tb_multicycle_control_fsm;
    localparam int WAIT_MAX = 4;

    localparam int C_R = 0, C_SH = 1, C_JR = 2, C_J = 3, C_JAL = 4, C_BEQ = 5,
                   C_BNE = 6, C_IS = 7, C_IZ = 8, C_LUI = 9, C_LW = 10,
                   C_SW = 11, C_HALT = 12, C_ILL = 13;

    localparam logic [3:0] A_SLL = 4'd0, A_SRL = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3,
                           A_AND = 4'd4, A_OR = 4'd5, A_XOR = 4'd6, A_NOR = 4'd7,
                           A_SLT = 4'd10, A_SLTU = 4'd11;

    typedef struct packed {
        logic [2:0] st;
        logic       iren, dren, dwen, irwen, pcwen, regwen, retire;
        logic [1:0] pcsrc, regdst, memtoreg;
        logic       halt, ill, tout;
    } exp_t;

    typedef struct {
        exp_t       e;
        exp_t       m;
        logic [7:0] alu, alum;
        bit         ih, dh, keep_pc;
    } step_t;

    typedef struct {
        logic [5:0] op, fn;
        int         cls;
        logic [3:0] aop;
    } ins_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_control_fsm_if #(.ALUOPW(4)) bus ();
    multicycle_control_fsm #(.WAIT_MAX(WAIT_MAX), .TIMEOUT_EN(1), .ALUOPW(4)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int     n_chk = 0;
    int     n_err = 0;
    ins_t   tbl[$];
    step_t  q[$];
    bit     mh, mi, mt, dead;
    string  sn[8] = '{"fetch", "decode", "exec", "mem", "wb", "halted", "s6", "s7"};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic exp_t obs();
        exp_t o;
        o.st = bus.state; o.iren = bus.iREN; o.dren = bus.dREN; o.dwen = bus.dWEN;
        o.irwen = bus.irWEN; o.pcwen = bus.pcWEN; o.regwen = bus.regWEN;
        o.retire = bus.retire; o.pcsrc = bus.pcSrc; o.regdst = bus.regDst;
        o.memtoreg = bus.memToReg; o.halt = bus.halt; o.ill = bus.illegal;
        o.tout = bus.memTimeout;
        return o;
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input int cls, input logic [3:0] aop);
        ins_t t;
        t.op = op; t.fn = fn; t.cls = cls; t.aop = aop;
        tbl.push_back(t);
    endtask

    function automatic ins_t lookup(input logic [5:0] op, input logic [5:0] fn);
        ins_t r;
        r.op = op; r.fn = fn; r.cls = C_ILL; r.aop = A_ADD;
        foreach (tbl[i])
            if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) r = tbl[i];
        return r;
    endfunction

    function automatic step_t mk(input logic [2:0] st);
        step_t s;
        s.e = '0; s.e.st = st; s.e.halt = mh; s.e.ill = mi; s.e.tout = mt;
        s.m = '1; s.alu = '0; s.alum = '0; s.ih = 0; s.dh = 0; s.keep_pc = 0;
        return s;
    endfunction

    // Selects only matter while the enable they steer is high.
    task automatic push(input step_t s);
        if (!s.keep_pc && !s.e.pcwen) s.m.pcsrc = '0;
        if (!s.e.regwen) begin s.m.regdst = '0; s.m.memtoreg = '0; end
        q.push_back(s);
    endtask

    task automatic halt_tail();
        for (int k = 0; k < 3; k++) push(mk(3'd5));
        dead = 1;
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int li, input int ld, input logic z);
        ins_t  t;
        step_t s;
        t = lookup(op, fn);
        q.delete();
        for (int k = 0; k < WAIT_MAX; k++) begin
            s = mk(3'd0); s.e.iren = 1;
            if (k == li) begin s.ih = 1; s.e.irwen = 1; s.e.pcwen = 1; end
            push(s);
            if (k == li) break;
        end
        if (li >= WAIT_MAX) begin mh = 1; mt = 1; halt_tail(); return; end

        s = mk(3'd1);
        case (t.cls)
            C_J:   begin s.e.pcwen = 1; s.e.pcsrc = 2; s.e.retire = 1; push(s); return; end
            C_JR:  begin s.e.pcwen = 1; s.e.pcsrc = 3; s.e.retire = 1; push(s); return; end
            C_JAL: begin
                s.e.pcwen = 1; s.e.pcsrc = 2; s.e.regwen = 1; s.e.regdst = 2;
                s.e.memtoreg = 2; s.e.retire = 1; push(s); return;
            end
            C_HALT: begin push(s); mh = 1; halt_tail(); return; end
            C_ILL:  begin push(s); mh = 1; mi = 1; halt_tail(); return; end
            default: push(s);
        endcase

        // alu vector is {aluSrc, extSel, aluOp}
        s = mk(3'd2);
        case (t.cls)
            C_R, C_BEQ, C_BNE: begin s.alu = {2'b00, 2'b00, t.aop}; s.alum = 8'b11_00_1111; end
            C_SH:              begin s.alu = {2'b10, 2'b00, t.aop}; s.alum = 8'b11_00_1111; end
            C_IS, C_LW, C_SW:  begin s.alu = {2'b01, 2'b01, t.aop}; s.alum = 8'hff; end
            C_IZ:              begin s.alu = {2'b01, 2'b00, t.aop}; s.alum = 8'hff; end
            default:           begin s.alu = {2'b00, 2'b10, 4'h0};  s.alum = 8'b00_11_0000; end
        endcase
        if (t.cls == C_BEQ || t.cls == C_BNE) begin
            s.e.pcwen = (t.cls == C_BEQ) ? z : !z;
            s.e.pcsrc = 1; s.keep_pc = 1; s.e.retire = 1;
            push(s);
            return;
        end
        push(s);

        if (t.cls == C_LW || t.cls == C_SW) begin
            for (int k = 0; k < WAIT_MAX; k++) begin
                s = mk(3'd3);
                s.e.dren = (t.cls == C_LW); s.e.dwen = (t.cls == C_SW);
                s.alu = {2'b01, 2'b00, A_ADD}; s.alum = 8'b11_00_1111;
                if (k == ld) begin s.dh = 1; s.e.retire = (t.cls == C_SW); end
                push(s);
                if (k == ld) break;
            end
            if (ld >= WAIT_MAX) begin mh = 1; mt = 1; halt_tail(); return; end
            if (t.cls == C_SW) return;
        end

        s = mk(3'd4);
        s.e.regwen = 1; s.e.retire = 1;
        s.e.regdst   = (t.cls == C_R || t.cls == C_SH) ? 2'd0 : 2'd1;
        s.e.memtoreg = (t.cls == C_LW) ? 2'd1 : (t.cls == C_LUI) ? 2'd3 : 2'd0;
        push(s);
    endtask

    // Each step begins just after a falling edge and ends on the next one.
    task automatic run_q(input bit rst_mem);
        for (int i = 0; i < q.size(); i++) begin
            bus.ihit = q[i].ih;
            bus.dhit = q[i].dh;
            #1;
            chk(sn[q[i].e.st], 32'(obs() & q[i].m), 32'(q[i].e & q[i].m));
            if (q[i].alum != 8'h00)
                chk("alu", 32'({bus.aluSrc, bus.extSel, bus.aluOp} & q[i].alum),
                    32'(q[i].alu & q[i].alum));
            if (rst_mem && q[i].e.st == 3'd3) begin
                nRST = 1'b0;
                #1;
                chk("rst_mem", 32'({bus.state, bus.dWEN, bus.iREN}), 32'(5'b000_0_1));
                @(negedge CLK);
                nRST = 1'b1; bus.ihit = 0; bus.dhit = 0;
                mh = 0; mi = 0; mt = 0; dead = 0;
                return;
            end
            @(negedge CLK);
        end
    endtask

    task automatic run_ins(input logic [5:0] op, input logic [5:0] fn, input int li,
                           input int ld, input logic z, input bit rst_mem);
        bus.opcode = op; bus.funct = fn; bus.zero = z;
        build(op, fn, li, ld, z);
        run_q(rst_mem);
    endtask

    task automatic do_reset();
        exp_t e;
        bus.ihit = 0; bus.dhit = 0;
        nRST = 1'b0;
        #1;
        e = '0; e.iren = 1;
        chk("rst", 32'(obs()), 32'(e));
        chk("rst_sel", 32'({bus.aluSrc, bus.extSel}), 32'(0));
        @(negedge CLK);
        nRST = 1'b1;
        mh = 0; mi = 0; mt = 0; dead = 0;
    endtask

    function automatic int lat();
        int r;
        r = int'($urandom_range(99));
        if (r < 85) return int'($urandom_range(2));
        if (r < 93) return WAIT_MAX - 1;
        return WAIT_MAX + 2;
    endfunction

    initial begin
        logic [5:0] op, fn;
        int         r;
        add(6'h00, 6'h20, C_R, A_ADD);   add(6'h00, 6'h21, C_R, A_ADD);
        add(6'h00, 6'h22, C_R, A_SUB);   add(6'h00, 6'h23, C_R, A_SUB);
        add(6'h00, 6'h24, C_R, A_AND);   add(6'h00, 6'h25, C_R, A_OR);
        add(6'h00, 6'h26, C_R, A_XOR);   add(6'h00, 6'h27, C_R, A_NOR);
        add(6'h00, 6'h2a, C_R, A_SLT);   add(6'h00, 6'h2b, C_R, A_SLTU);
        add(6'h00, 6'h00, C_SH, A_SLL);  add(6'h00, 6'h02, C_SH, A_SRL);
        add(6'h00, 6'h08, C_JR, A_ADD);  add(6'h02, 6'h00, C_J, A_ADD);
        add(6'h03, 6'h00, C_JAL, A_ADD); add(6'h04, 6'h00, C_BEQ, A_SUB);
        add(6'h05, 6'h00, C_BNE, A_SUB); add(6'h08, 6'h00, C_IS, A_ADD);
        add(6'h09, 6'h00, C_IS, A_ADD);  add(6'h0a, 6'h00, C_IS, A_SLT);
        add(6'h0b, 6'h00, C_IS, A_SLTU); add(6'h0c, 6'h00, C_IZ, A_AND);
        add(6'h0d, 6'h00, C_IZ, A_OR);   add(6'h0e, 6'h00, C_IZ, A_XOR);
        add(6'h0f, 6'h00, C_LUI, A_ADD); add(6'h23, 6'h00, C_LW, A_ADD);
        add(6'h2b, 6'h00, C_SW, A_ADD);  add(6'h3f, 6'h00, C_HALT, A_ADD);

        bus.opcode = 6'h00; bus.funct = 6'h21; bus.zero = 0;
        bus.ihit = 0; bus.dhit = 0;
        @(negedge CLK);
        do_reset();

        run_ins(6'h00, 6'h21, 0, 0, 0, 0);          // ADDU
        run_ins(6'h23, 6'h00, 0, 2, 0, 0);          // LW, dhit on third MEM cycle
        run_ins(6'h04, 6'h00, 0, 0, 1, 0);          // BEQ taken
        run_ins(6'h05, 6'h00, 1, 0, 1, 0);          // BNE not taken
        run_ins(6'h03, 6'h00, 0, 0, 0, 0);          // JAL
        run_ins(6'h00, 6'h08, 2, 0, 0, 0);          // JR
        run_ins(6'h2b, 6'h00, 0, 1, 0, 0);          // SW
        run_ins(6'h0f, 6'h00, 0, 0, 0, 0);          // LUI
        run_ins(6'h00, 6'h21, WAIT_MAX - 1, 0, 0, 0); // late ihit, no timeout
        run_ins(6'h23, 6'h00, 0, WAIT_MAX - 1, 0, 0); // late dhit, no timeout
        run_ins(6'h00, 6'h21, 99, 0, 0, 0);         // ihit never arrives
        do_reset();
        run_ins(6'h2b, 6'h00, 0, 99, 0, 0);         // dhit never arrives
        do_reset();
        run_ins(6'h10, 6'h00, 0, 0, 0, 0);          // illegal opcode
        do_reset();
        run_ins(6'h00, 6'h3f, 0, 0, 0, 0);          // illegal funct
        do_reset();
        run_ins(6'h2b, 6'h00, 0, 3, 0, 1);          // reset during SW MEM
        run_ins(6'h00, 6'h20, 0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if (dead) do_reset();
            r = int'($urandom_range(99));
            if (r < 4) begin
                op = 6'h10 + 6'($urandom_range(15)); fn = 6'($urandom);
            end else if (r < 6) begin
                op = 6'h00; fn = 6'h30 + 6'($urandom_range(15));
            end else begin
                op = tbl[$urandom_range(tbl.size() - 1)].op;
                fn = tbl[$urandom_range(tbl.size() - 1)].fn;
                if (op != 6'h00) fn = 6'($urandom);
                else begin
                    ins_t t;
                    do t = tbl[$urandom_range(tbl.size() - 1)]; while (t.op != 6'h00);
                    fn = t.fn;
                end
            end
            run_ins(op, fn, lat(), lat(), 1'($urandom), ($urandom_range(99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
